// File: rtl/amo_agent_if.sv
// Shared types and the agent-side bundle for the atomic-request sequencer.
//
// amo_agent_pkg : RMW operation encoding (amo_t) and request type codes.
// amo_agent_if  : groups the LSU request/response handshake, the single-
//                 outstanding memory port and the atomic-unit agent slot.
//   modport master : the amo_agent itself (drives req_ready, resp_*, mem_*,
//                    reservation pulses and the ALU request)
//   modport slave  : the surroundings (LSU, memory, shared atomic unit)

package amo_agent_pkg;
   typedef enum logic [3:0] {
      AMO_SWAP = 4'd0,
      AMO_ADD  = 4'd1,
      AMO_XOR  = 4'd2,
      AMO_AND  = 4'd3,
      AMO_OR   = 4'd4,
      AMO_MIN  = 4'd5,
      AMO_MAX  = 4'd6,
      AMO_MINU = 4'd7,
      AMO_MAXU = 4'd8
   } amo_t;

   localparam logic [1:0] REQ_LR   = 2'd0;
   localparam logic [1:0] REQ_SC   = 2'd1;
   localparam logic [1:0] REQ_RMW  = 2'd2;
   localparam logic [1:0] REQ_RSVD = 2'd3;
endpackage

interface amo_agent_if #(parameter int ID_W = 4);
   // LSU request / response
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_type;
   amo_agent_pkg::amo_t  req_op;
   logic [31:0]          req_addr;
   logic [31:0]          req_data;
   logic [ID_W-1:0]      req_id;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [31:0]          resp_data;
   logic                 resp_err;
   logic [ID_W-1:0]      resp_id;
   // memory port
   logic                 mem_valid;
   logic                 mem_ready;
   logic                 mem_we;
   logic [31:0]          mem_addr;
   logic [31:0]          mem_wdata;
   logic                 mem_rvalid;
   logic [31:0]          mem_rdata;
   // atomic unit agent slot
   logic                 set_reservation;
   logic                 clear_reservation;
   logic [31:0]          reservation;
   logic                 reservation_valid;
   logic                 rmw_valid;
   amo_agent_pkg::amo_t  op;
   logic [31:0]          rs1;
   logic [31:0]          rs2;
   logic [31:0]          rd;

   modport master (
      input  req_valid, req_type, req_op, req_addr, req_data, req_id,
      output req_ready,
      output resp_valid, resp_data, resp_err, resp_id,
      input  resp_ready,
      output mem_valid, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata,
      output set_reservation, clear_reservation, reservation,
      input  reservation_valid,
      output rmw_valid, op, rs1, rs2,
      input  rd
   );

   modport slave (
      output req_valid, req_type, req_op, req_addr, req_data, req_id,
      input  req_ready,
      input  resp_valid, resp_data, resp_err, resp_id,
      output resp_ready,
      input  mem_valid, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata,
      input  set_reservation, clear_reservation, reservation,
      output reservation_valid,
      input  rmw_valid, op, rs1, rs2,
      output rd
   );
endinterface

// File: rtl/amo_agent.sv
// amo_agent: initiator-side sequencer for LR.W / SC.W / AMO read-modify-write.
// Takes one request at a time, runs the memory reads/writes on a single-
// outstanding port, drives the reservation pulses and the RMW ALU request of
// one agent slot in the shared atomic unit, and returns one response.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - amo_agent_if.master: request/response handshake, memory port,
//          reservation set/clear/check and ALU request (rd comes back
//          combinationally in the same cycle)

module amo_agent #(
   parameter int ID_W = 4
) (
   input logic         clk,
   input logic         rst,
   amo_agent_if.master bus
);
   import amo_agent_pkg::*;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_SC_CHECK, S_WR_REQ, S_RESP
   } state_e;

   state_e          state_q;
   logic [1:0]      type_q;
   amo_t            op_q;
   logic [31:0]     addr_q;
   logic [31:0]     data_q;
   logic [31:0]     old_q;
   logic [31:0]     resp_data_q;
   logic            resp_err_q;
   logic [ID_W-1:0] id_q;

   logic is_lr, is_sc, is_rmw, acc_err;

   assign is_lr   = (type_q == REQ_LR);
   assign is_sc   = (type_q == REQ_SC);
   assign is_rmw  = (type_q == REQ_RMW);
   // Rejected on acceptance; never touches memory or the reservation.
   assign acc_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_type == REQ_RSVD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         type_q      <= 2'd0;
         op_q        <= AMO_SWAP;
         addr_q      <= 32'd0;
         data_q      <= 32'd0;
         old_q       <= 32'd0;
         resp_data_q <= 32'd0;
         resp_err_q  <= 1'b0;
         id_q        <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  type_q     <= bus.req_type;
                  op_q       <= bus.req_op;
                  addr_q     <= bus.req_addr;
                  data_q     <= bus.req_data;
                  id_q       <= bus.req_id;
                  resp_err_q <= acc_err;
                  if (acc_err) begin
                     resp_data_q <= 32'd0;
                     state_q     <= S_RESP;
                  end else if (bus.req_type == REQ_SC) begin
                     state_q <= S_SC_CHECK;
                  end else begin
                     state_q <= S_RD_REQ;
                  end
               end
            end
            S_RD_REQ: begin
               if (bus.mem_ready) state_q <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               // Returns are only meaningful here; anywhere else they are stale.
               if (bus.mem_rvalid) begin
                  old_q <= bus.mem_rdata;
                  if (is_lr) begin
                     resp_data_q <= bus.mem_rdata;
                     state_q     <= S_RESP;
                  end else begin
                     state_q <= S_WR_REQ;
                  end
               end
            end
            S_SC_CHECK: begin
               // reservation has been on the bus for exactly this one cycle.
               if (bus.reservation_valid) begin
                  state_q <= S_WR_REQ;
               end else begin
                  resp_data_q <= 32'd1;
                  state_q     <= S_RESP;
               end
            end
            S_WR_REQ: begin
               if (bus.mem_ready) begin
                  resp_data_q <= is_sc ? 32'd0 : old_q;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   logic in_rd_req, in_rd_wait, in_sc_chk, in_wr_req, in_resp;

   assign in_rd_req  = (state_q == S_RD_REQ);
   assign in_rd_wait = (state_q == S_RD_WAIT);
   assign in_sc_chk  = (state_q == S_SC_CHECK);
   assign in_wr_req  = (state_q == S_WR_REQ);
   assign in_resp    = (state_q == S_RESP);

   assign bus.req_ready  = (state_q == S_IDLE);

   assign bus.resp_valid = in_resp;
   assign bus.resp_data  = in_resp ? resp_data_q : 32'd0;
   assign bus.resp_err   = in_resp & resp_err_q;
   assign bus.resp_id    = in_resp ? id_q : '0;

   assign bus.mem_valid  = in_rd_req | in_wr_req;
   assign bus.mem_we     = in_wr_req;
   assign bus.mem_addr   = (in_rd_req | in_wr_req) ? addr_q : 32'd0;
   // RMW store data is the ALU result, taken straight through with no register.
   assign bus.mem_wdata  = !in_wr_req ? 32'd0 : (is_rmw ? bus.rd : data_q);

   assign bus.rmw_valid  = in_wr_req & is_rmw;
   assign bus.op         = (in_wr_req & is_rmw) ? op_q  : AMO_SWAP;
   assign bus.rs1        = (in_wr_req & is_rmw) ? old_q : 32'd0;
   assign bus.rs2        = (in_wr_req & is_rmw) ? data_q : 32'd0;

   // Set only in RD_WAIT, clear only in SC_CHECK/WR_REQ: never coincide.
   assign bus.set_reservation   = in_rd_wait & bus.mem_rvalid & is_lr;
   assign bus.clear_reservation = (in_sc_chk & ~bus.reservation_valid)
                                | (in_wr_req & bus.mem_ready);
   assign bus.reservation       = (in_rd_wait | in_sc_chk) ? addr_q : 32'd0;
endmodule

// File: tb/tb_amo_agent.sv
// Testbench for amo_agent: table of directed requests with hand-computed
// results and latencies, plus hand-written sequences for write stall /
// response backpressure and reset during an outstanding read.

module tb_amo_agent;
   import amo_agent_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   amo_agent_if #(.ID_W(4)) bus();

   amo_agent #(.ID_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // Reference RMW ALU standing in for the shared atomic unit.
   function automatic logic [31:0] alu(input amo_t o, input logic [31:0] a,
                                       input logic [31:0] b);
      case (o)
         AMO_SWAP: return b;
         AMO_ADD:  return a + b;
         AMO_XOR:  return a ^ b;
         AMO_AND:  return a & b;
         AMO_OR:   return a | b;
         AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
         AMO_MAX:  return ($signed(a) > $signed(b)) ? a : b;
         AMO_MINU: return (a < b) ? a : b;
         AMO_MAXU: return (a > b) ? a : b;
         default:  return 32'd0;
      endcase
   endfunction

   assign bus.rd = alu(bus.op, bus.rs1, bus.rs2);

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  typ;
      amo_t        op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      logic [3:0]  id;
      logic        rv;
      logic [31:0] e_data;
      logic        e_err;
      int          e_lat;
      int          e_rd;
      int          e_wr;
      logic [31:0] e_wdata;
      int          e_set;
      int          e_clr;
   } vec_t;

   vec_t vecs[12];

   // Zero-wait memory: mem_ready whenever mem_valid, read data one cycle later.
   task automatic run_vec(input int idx, input vec_t v);
      int          lat   = -1;
      int          nrd   = 0;
      int          nwr   = 0;
      int          nset  = 0;
      int          nclr  = 0;
      int          nboth = 0;
      int          nbad  = 0;
      logic [31:0] wdata = 32'd0;
      logic        pend  = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_type  = v.typ;
      bus.req_op    = v.op;
      bus.req_addr  = v.addr;
      bus.req_data  = v.data;
      bus.req_id    = v.id;
      bus.reservation_valid = v.rv;
      #1 chk($sformatf("v%0d req_ready", idx), 32'(bus.req_ready), 32'd1);
      for (int k = 1; k < 40; k++) begin
         @(negedge clk);
         bus.req_valid  = 1'b0;
         bus.mem_rvalid = pend;
         bus.mem_rdata  = pend ? v.rdata : 32'd0;
         pend           = 1'b0;
         bus.mem_ready  = bus.mem_valid;
         #1;
         if (bus.resp_valid) begin
            lat = k;
            break;
         end
         if (bus.mem_valid && bus.mem_ready) begin
            if (bus.mem_addr != v.addr) nbad++;
            if (bus.mem_we) begin
               nwr++;
               wdata = bus.mem_wdata;
            end else begin
               nrd++;
               pend = 1'b1;
            end
         end
         if (bus.set_reservation) begin
            nset++;
            if (bus.reservation != v.addr) nbad++;
         end
         if (bus.clear_reservation) nclr++;
         if (bus.set_reservation && bus.clear_reservation) nboth++;
      end
      chk($sformatf("v%0d latency", idx),   lat,                  v.e_lat);
      chk($sformatf("v%0d resp_data", idx), bus.resp_data,        v.e_data);
      chk($sformatf("v%0d resp_err", idx),  32'(bus.resp_err),    32'(v.e_err));
      chk($sformatf("v%0d resp_id", idx),   32'(bus.resp_id),     32'(v.id));
      chk($sformatf("v%0d reads", idx),     nrd,                  v.e_rd);
      chk($sformatf("v%0d writes", idx),    nwr,                  v.e_wr);
      chk($sformatf("v%0d wdata", idx),     wdata,                v.e_wdata);
      chk($sformatf("v%0d set_pulses", idx), nset,                v.e_set);
      chk($sformatf("v%0d clr_pulses", idx), nclr,                v.e_clr);
      chk($sformatf("v%0d both_pulses", idx), nboth,              0);
      chk($sformatf("v%0d bad_addr", idx),  nbad,                 0);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'd0;
      #1;
      chk($sformatf("v%0d idle_ready", idx), 32'(bus.req_ready),  32'd1);
      chk($sformatf("v%0d idle_resp", idx),  32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      bus.req_valid = 1'b0; bus.req_type = 2'd0; bus.req_op = AMO_SWAP;
      bus.req_addr = 32'd0; bus.req_data = 32'd0; bus.req_id = 4'd0;
      bus.resp_ready = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
      bus.mem_rdata = 32'd0; bus.reservation_valid = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst req_ready",  32'(bus.req_ready),  32'd1);
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst mem_valid",  32'(bus.mem_valid),  32'd0);
      chk("rst set_res",    32'(bus.set_reservation), 32'd0);
      chk("rst clr_res",    32'(bus.clear_reservation), 32'd0);
      chk("rst rmw_valid",  32'(bus.rmw_valid),  32'd0);
      @(negedge clk);
      rst = 1'b1;

      //        typ    op        addr          data          rdata         id    rv    e_data        err lat rd wr e_wdata       set clr
      vecs[0]  = '{REQ_LR,  AMO_SWAP, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 4'h1, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0, 32'h0,        1, 0};
      vecs[1]  = '{REQ_SC,  AMO_SWAP, 32'h0000_1000, 32'h55,       32'h0,        4'h2, 1'b1, 32'h0,         1'b0, 3, 0, 1, 32'h55,       0, 1};
      vecs[2]  = '{REQ_SC,  AMO_SWAP, 32'h0000_1000, 32'h55,       32'h0,        4'h3, 1'b0, 32'h1,         1'b0, 2, 0, 0, 32'h0,        0, 1};
      vecs[3]  = '{REQ_RMW, AMO_ADD,  32'h0000_2000, 32'h7,        32'h5,        4'h4, 1'b0, 32'h5,         1'b0, 4, 1, 1, 32'hC,        0, 1};
      vecs[4]  = '{REQ_LR,  AMO_SWAP, 32'h0000_1002, 32'h0,        32'h0,        4'h5, 1'b0, 32'h0,         1'b1, 1, 0, 0, 32'h0,        0, 0};
      vecs[5]  = '{REQ_RSVD, AMO_SWAP, 32'h0000_3000, 32'h9,       32'h0,        4'h6, 1'b1, 32'h0,         1'b1, 1, 0, 0, 32'h0,        0, 0};
      vecs[6]  = '{REQ_RMW, AMO_XOR,  32'h0000_2004, 32'hFF,       32'hF0F0,     4'h7, 1'b0, 32'hF0F0,      1'b0, 4, 1, 1, 32'hF00F,     0, 1};
      vecs[7]  = '{REQ_RMW, AMO_SWAP, 32'h0000_0010, 32'h1234,     32'hAB,       4'h8, 1'b0, 32'hAB,        1'b0, 4, 1, 1, 32'h1234,     0, 1};
      vecs[8]  = '{REQ_LR,  AMO_SWAP, 32'h0000_0000, 32'h0,        32'h1234_5678, 4'h9, 1'b0, 32'h1234_5678, 1'b0, 3, 1, 0, 32'h0,       1, 0};
      vecs[9]  = '{REQ_SC,  AMO_SWAP, 32'h0000_1001, 32'h77,       32'h0,        4'hA, 1'b1, 32'h0,         1'b1, 1, 0, 0, 32'h0,        0, 0};
      vecs[10] = '{REQ_RMW, AMO_MINU, 32'h0000_0040, 32'h3,        32'hFFFF_FFFF, 4'hB, 1'b0, 32'hFFFF_FFFF, 1'b0, 4, 1, 1, 32'h3,       0, 1};
      vecs[11] = '{REQ_RMW, AMO_MAX,  32'h0000_0044, 32'h2,        32'hFFFF_FFFE, 4'hC, 1'b0, 32'hFFFF_FFFE, 1'b0, 4, 1, 1, 32'h2,       0, 1};

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // RMW with the write stalled 3 cycles, then response held off 4 cycles.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_type = REQ_RMW; bus.req_op = AMO_ADD;
      bus.req_addr = 32'h2000; bus.req_data = 32'd7; bus.req_id = 4'hA;
      bus.reservation_valid = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'd5;
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk($sformatf("stall%0d mem_valid", s), 32'(bus.mem_valid), 32'd1);
         chk($sformatf("stall%0d mem_we", s),    32'(bus.mem_we),    32'd1);
         chk($sformatf("stall%0d mem_addr", s),  bus.mem_addr,       32'h2000);
         chk($sformatf("stall%0d wdata", s),     bus.mem_wdata,      32'd12);
         chk($sformatf("stall%0d rmw_valid", s), 32'(bus.rmw_valid), 32'd1);
         chk($sformatf("stall%0d op", s),        32'(bus.op),        32'(AMO_ADD));
         chk($sformatf("stall%0d rs1", s),       bus.rs1,            32'd5);
         chk($sformatf("stall%0d rs2", s),       bus.rs2,            32'd7);
         chk($sformatf("stall%0d clr", s),       32'(bus.clear_reservation), 32'd0);
         @(negedge clk);
      end
      bus.mem_ready = 1'b1;
      #1 chk("stall wr clr", 32'(bus.clear_reservation), 32'd1);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         #1;
         chk($sformatf("hold%0d resp_valid", s), 32'(bus.resp_valid), 32'd1);
         chk($sformatf("hold%0d resp_data", s),  bus.resp_data,       32'd5);
         chk($sformatf("hold%0d resp_id", s),    32'(bus.resp_id),    32'hA);
         chk($sformatf("hold%0d req_ready", s),  32'(bus.req_ready),  32'd0);
         @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      #1 chk("hold idle req_ready", 32'(bus.req_ready), 32'd1);

      // Reset while an LR read is outstanding, then a late stray return.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_type = REQ_LR; bus.req_op = AMO_SWAP;
      bus.req_addr = 32'h4000; bus.req_id = 4'h3;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("mrst req_ready",   32'(bus.req_ready),  32'd1);
      chk("mrst resp_valid",  32'(bus.resp_valid), 32'd0);
      chk("mrst mem_valid",   32'(bus.mem_valid),  32'd0);
      chk("mrst mem_addr",    bus.mem_addr,        32'd0);
      chk("mrst reservation", bus.reservation,     32'd0);
      chk("mrst resp_id",     32'(bus.resp_id),    32'd0);
      @(negedge clk);
      rst = 1'b1;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0BAD;
      #1 chk("stray set_res", 32'(bus.set_reservation), 32'd0);
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
      for (int s = 0; s < 4; s++) begin
         #1;
         chk($sformatf("stray%0d resp_valid", s), 32'(bus.resp_valid), 32'd0);
         chk($sformatf("stray%0d req_ready", s),  32'(bus.req_ready),  32'd1);
         chk($sformatf("stray%0d mem_valid", s),  32'(bus.mem_valid),  32'd0);
         @(negedge clk);
      end
      run_vec(12, vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
